scalar_operand_stage: RTL and testbench

Holds the scalar operand (rs1 / immediate) of an accepted vector-scalar instruction, along with its element width, signedness and vector length. Presents it to the scalar replication stage once per execution beat until all `ceil(vl/4)` beats have been consumed by the 4-PE datapath. It sits between the instruction decode/offload interface and scalar replication. A 2-entry queue lets the next instruction's operand be accepted while the current one is still iterating.

---
 rtl/scalar_operand_stage.sv | 141 ++++++++++++++
 tb/tb_scalar_operand_stage.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scalar_operand_stage.sv
// Scalar operand queue for vector-scalar ops: holds rs1/imm per instruction
// and replays it once per 4-lane beat until ceil(vl/4) beats are consumed.
module scalar_operand_stage #(
  parameter int DEPTH = 2,
  parameter int LANES = 4,
  parameter int VL_W  = 7
) (
  input  logic            clk,
  input  logic            n_reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_scalar,
  input  logic [1:0]      in_vsew,
  input  logic            in_us,
  input  logic [VL_W-1:0] in_vl,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_scalar,
  output logic [1:0]      out_vsew,
  output logic            out_us,
  output logic [VL_W-3:0] out_beat,
  output logic            out_last
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int LG = $clog2(LANES);
  localparam int BW = VL_W - 1;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ISSUE,
    S_SKIP
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [31:0]     r_scalar [DEPTH];
  logic [1:0]      r_vsew   [DEPTH];
  logic            r_us     [DEPTH];
  logic [BW-1:0]   r_beats  [DEPTH];

  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic [VL_W-3:0] r_beat_cnt;

  logic [VL_W:0]   w_vl_sum;
  logic [BW-1:0]   w_in_beats;
  logic [BW-1:0]   w_head_beats;
  logic [BW-1:0]   w_nxt_beats;
  logic            w_acc;
  logic            w_xfer;
  logic            w_last;
  logic            w_pop;
  logic [PW-1:0]   w_wptr_inc;
  logic [PW-1:0]   w_rptr_inc;
  logic [PW-1:0]   w_rptr_nxt;
  logic [CW-1:0]   w_cnt_nxt;

  // beats = ceil(vl / LANES), kept one bit narrower than vl
  assign w_vl_sum   = {1'b0, in_vl} + (VL_W+1)'(LANES - 1);
  assign w_in_beats = BW'(w_vl_sum >> LG);

  assign in_ready = (r_count != CW'(DEPTH)) && n_reset;
  assign w_acc    = in_valid && in_ready;

  assign w_head_beats = r_beats[r_rptr];
  assign out_valid    = (r_state == S_ISSUE);
  assign out_scalar   = r_scalar[r_rptr];
  assign out_vsew     = r_vsew[r_rptr];
  assign out_us       = r_us[r_rptr];
  assign out_beat     = r_beat_cnt;

  assign w_last   = ({1'b0, r_beat_cnt} == (w_head_beats - 1'b1));
  assign out_last = out_valid && w_last;

  assign w_xfer = out_valid && out_ready;
  assign w_pop  = (w_xfer && w_last) || (r_state == S_SKIP);

  assign w_wptr_inc = (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
  assign w_rptr_inc = (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
  assign w_rptr_nxt = w_pop ? w_rptr_inc : r_rptr;
  assign w_cnt_nxt  = r_count + CW'(w_acc) - CW'(w_pop);

  // New head may be the entry being written this very cycle
  assign w_nxt_beats = (w_acc && (r_wptr == w_rptr_nxt))
                     ? w_in_beats
                     : r_beats[w_rptr_nxt];

  always_comb begin
    w_state_nxt = S_EMPTY;
    if (flush || (w_cnt_nxt == '0))
      w_state_nxt = S_EMPTY;
    else if (w_nxt_beats == '0)
      w_state_nxt = S_SKIP;
    else
      w_state_nxt = S_ISSUE;
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_scalar[i] <= '0;
        r_vsew[i]   <= '0;
        r_us[i]     <= 1'b0;
        r_beats[i]  <= '0;
      end
    end else if (w_acc && !flush) begin
      r_scalar[r_wptr] <= in_scalar;
      r_vsew[r_wptr]   <= in_vsew;
      r_us[r_wptr]     <= in_us;
      r_beats[r_wptr]  <= w_in_beats;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_state    <= S_EMPTY;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_beat_cnt <= '0;
    end else if (flush) begin
      r_state    <= S_EMPTY;
      r_count    <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_cnt_nxt;
      r_rptr  <= w_rptr_nxt;
      if (w_acc)
        r_wptr <= w_wptr_inc;
      if (w_xfer)
        r_beat_cnt <= w_last ? '0 : r_beat_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_scalar_operand_stage.sv
// Directed bench for scalar_operand_stage: beat sequencing, queueing,
// skip, flush and reset behaviour against hand-computed vectors.
module tb_scalar_operand_stage;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_scalar;
  logic [1:0]  in_vsew;
  logic        in_us;
  logic [6:0]  in_vl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_scalar;
  logic [1:0]  out_vsew;
  logic        out_us;
  logic [4:0]  out_beat;
  logic        out_last;

  logic [41:0] obs;
  logic [41:0] exp_v;
  int n_checks = 0;
  int n_fail = 0;

  assign obs = {out_valid, out_last, out_beat,
                out_vsew, out_us, out_scalar};

  always #5 clk = ~clk;

  scalar_operand_stage #(.DEPTH(2), .LANES(4), .VL_W(7)) dut (
    .clk(clk),
    .n_reset(n_reset),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_scalar(in_scalar),
    .in_vsew(in_vsew),
    .in_us(in_us),
    .in_vl(in_vl),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_scalar(out_scalar),
    .out_vsew(out_vsew),
    .out_us(out_us),
    .out_beat(out_beat),
    .out_last(out_last)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] s,
                       input logic [1:0] w, input logic u,
                       input logic [6:0] l);
    in_valid  = v;
    in_scalar = s;
    in_vsew   = w;
    in_us     = u;
    in_vl     = l;
  endtask

  task automatic test_reset();
    n_reset = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 32'h0, 2'd0, 1'b0, 7'd0);
    tick();
    tick();
    exp_v = '0;
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected %h", obs, exp_v);
    end
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b expected 0", in_ready);
    end
    n_reset = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    drive(1'b1, 32'h0000_00F3, 2'd0, 1'b0, 7'd9);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL single_ready: got %b expected 1", in_ready);
    end
    tick();
    drive(1'b0, 32'h0, 2'd0, 1'b0, 7'd0);
    for (int i = 0; i < 3; i++) begin
      exp_v = {1'b1, (i == 2), 5'(i), 2'd0, 1'b0, 32'h0000_00F3};
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL single_beat%0d: got %h expected %h",
                 i, obs, exp_v);
      end
      tick();
    end
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    drive(1'b1, 32'hAAAA_0001, 2'd1, 1'b1, 7'd4);
    tick();
    drive(1'b1, 32'hBBBB_0002, 2'd2, 1'b0, 7'd8);
    exp_v = {1'b1, 1'b1, 5'd0, 2'd1, 1'b1, 32'hAAAA_0001};
    n_checks++;
    if (obs !== exp_v || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_a0: got %h/%b expected %h/1",
               obs, in_ready, exp_v);
    end
    tick();
    drive(1'b0, 32'h0, 2'd0, 1'b0, 7'd0);
    for (int i = 0; i < 2; i++) begin
      exp_v = {1'b1, (i == 1), 5'(i), 2'd2, 1'b0, 32'hBBBB_0002};
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL b2b_b%0d: got %h expected %h", i, obs, exp_v);
      end
      tick();
    end
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    drive(1'b1, 32'hC1C1_C1C1, 2'd0, 1'b0, 7'd4);
    tick();
    drive(1'b1, 32'hC2C2_C2C2, 2'd1, 1'b0, 7'd3);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_ready1: got %b expected 1", in_ready);
    end
    tick();
    drive(1'b1, 32'hC3C3_C3C3, 2'd2, 1'b1, 7'd2);
    exp_v = {1'b1, 1'b1, 5'd0, 2'd0, 1'b0, 32'hC1C1_C1C1};
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (obs !== exp_v || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got %h/%b expected %h/0",
                 i, obs, in_ready, exp_v);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_no_bypass: got %b expected 0", in_ready);
    end
    tick();
    exp_v = {1'b1, 1'b1, 5'd0, 2'd1, 1'b0, 32'hC2C2_C2C2};
    n_checks++;
    if (obs !== exp_v || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_c2: got %h/%b expected %h/1",
               obs, in_ready, exp_v);
    end
    tick();
    drive(1'b0, 32'h0, 2'd0, 1'b0, 7'd0);
    exp_v = {1'b1, 1'b1, 5'd0, 2'd2, 1'b1, 32'hC3C3_C3C3};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL stall_c3: got %h expected %h", obs, exp_v);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_idle: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_skip();
    out_ready = 1'b1;
    drive(1'b1, 32'h5555_0000, 2'd0, 1'b0, 7'd0);
    tick();
    drive(1'b1, 32'h5555_0001, 2'd3, 1'b1, 7'd1);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL skip_cycle: got %b/%b expected 0/1",
               out_valid, in_ready);
    end
    tick();
    drive(1'b0, 32'h0, 2'd0, 1'b0, 7'd0);
    exp_v = {1'b1, 1'b1, 5'd0, 2'd3, 1'b1, 32'h5555_0001};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL skip_next: got %h expected %h", obs, exp_v);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL skip_idle: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    drive(1'b1, 32'hF1F1_0001, 2'd0, 1'b0, 7'd8);
    tick();
    drive(1'b1, 32'hF2F2_0002, 2'd0, 1'b0, 7'd4);
    tick();
    exp_v = {1'b1, 1'b1, 5'd1, 2'd0, 1'b0, 32'hF1F1_0001};
    n_checks++;
    if (obs !== exp_v || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_pre: got %h/%b expected %h/0",
               obs, in_ready, exp_v);
    end
    flush = 1'b1;
    out_ready = 1'b0;
    drive(1'b1, 32'hF3F3_0003, 2'd0, 1'b0, 7'd4);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 2'd0, 1'b0, 7'd0);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
        out_beat !== 5'd0 || out_last !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_after: got v%b r%b b%0d l%b expected v0 r1 b0 l0",
               out_valid, in_ready, out_beat, out_last);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_drained: got %b expected 0", out_valid);
    end
    flush = 1'b1;
    drive(1'b1, 32'hF4F4_0004, 2'd0, 1'b0, 7'd4);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_ready_ungated: got %b expected 1", in_ready);
    end
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 2'd0, 1'b0, 7'd0);
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_drop_input: got %b expected 0", out_valid);
    end
    out_ready = 1'b1;
    drive(1'b1, 32'hF5F5_0005, 2'd1, 1'b1, 7'd4);
    tick();
    drive(1'b0, 32'h0, 2'd0, 1'b0, 7'd0);
    exp_v = {1'b1, 1'b1, 5'd0, 2'd1, 1'b1, 32'hF5F5_0005};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL flush_restart: got %h expected %h", obs, exp_v);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    drive(1'b1, 32'h7777_0001, 2'd2, 1'b0, 7'd16);
    tick();
    drive(1'b0, 32'h0, 2'd0, 1'b0, 7'd0);
    exp_v = {1'b1, 1'b0, 5'd0, 2'd2, 1'b0, 32'h7777_0001};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL rmid_beat0: got %h expected %h", obs, exp_v);
    end
    tick();
    n_reset = 1'b0;
    #1;
    n_checks++;
    if (out_beat !== 5'd1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_beat1: got b%0d r%b expected b1 r0",
               out_beat, in_ready);
    end
    tick();
    n_reset = 1'b1;
    #1;
    exp_v = '0;
    n_checks++;
    if (obs !== exp_v || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_after: got %h/%b expected %h/1",
               obs, in_ready, exp_v);
    end
    drive(1'b1, 32'h8888_0002, 2'd0, 1'b1, 7'd8);
    tick();
    drive(1'b0, 32'h0, 2'd0, 1'b0, 7'd0);
    for (int i = 0; i < 2; i++) begin
      exp_v = {1'b1, (i == 1), 5'(i), 2'd0, 1'b1, 32'h8888_0002};
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL rmid_new%0d: got %h expected %h", i, obs, exp_v);
      end
      tick();
    end
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_idle: got %b expected 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_skip();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
